world_step_sequencer: RTL
=========================

// Module: world_step_sequencer
// PURPOSE
//   Sequences one simulated world step: sense -> settle -> robot clock pulse -> update.
//   Replaces the free-running divided robot clock with a run/pause/single-step controller.
//   Sits between the remote-controller command decoder and the world map/robot logic.
//   sense_en drives sensor evaluation, robot_clock drives the robot FSM, and update_en
//   drives the position/trash-removal update.
// PARAMETERS
//   DIV_FACTOR     28'd200000000  idle cycles in S_WAIT between steps while running (>=1)
//   SETTLE_CYCLES  2              cycles between sense_en and robot_clock rise (>=1)
//   HOLD_CYCLES    4              cycles robot_clock is held high (>=1)
//   MAX_STEPS      16'd1000       step limit; used only with WORLD_STEP_LIMIT_EN
// PORTS
//   clock_50     in   1   system clock
//   reset_key    in   1   asynchronous reset, active-low
//   cmd_valid    in   1   command present
//   cmd_code     in   2   00 NOP, 01 RUN, 10 PAUSE, 11 STEP
//   cmd_ready    out  1   command accepted when cmd_valid & cmd_ready
//   sense_en     out  1   1-cycle strobe: latch head/left/under/barrier
//   robot_clock  out  1   clock to robot; high for HOLD_CYCLES per step
//   update_en    out  1   1-cycle strobe: apply front/turn/remove to world
//   running      out  1   continuous-run mode active
//   busy         out  1   step sequence in progress (S_SENSE..S_UPDATE)
//   step_count   out  16  completed steps (0 without WORLD_STEP_LIMIT_EN)
//   limit_hit    out  1   sticky; step limit reached (0 without WORLD_STEP_LIMIT_EN)
// BEHAVIOUR
//   - Reset (async, reset_key=0): state S_STOP; counters = 0; all outputs 0 except
//     cmd_ready = 1. Reset mid-step drops robot_clock immediately; no update_en is issued.
//   - All outputs are registered and decoded from the state register.
//   - States: S_STOP, S_WAIT, S_SENSE, S_SETTLE, S_CLK, S_UPDATE.
//   - cmd_ready = 1 in S_STOP and S_WAIT only; steps are atomic. A command presented
//     during busy stalls until the sequence ends.
//   - S_STOP: RUN -> running=1, S_SENSE; STEP -> S_SENSE (running stays 0);
//     PAUSE/NOP -> stay.
//   - S_SENSE: 1 cycle, sense_en=1 -> S_SETTLE.
//   - S_SETTLE: SETTLE_CYCLES cycles -> S_CLK.
//   - S_CLK: HOLD_CYCLES cycles, robot_clock=1 -> S_UPDATE.
//   - S_UPDATE: 1 cycle, update_en=1, robot_clock=0. Next state is S_WAIT if running,
//     otherwise S_STOP.
//   - Step latency: sense_en 1 cycle after acceptance, update_en 2+SETTLE+HOLD cycles after.
//   - S_WAIT: 28-bit counter runs from 0. At DIV_FACTOR-1: clear, go to S_SENSE.
//     PAUSE -> running=0, S_STOP, counter cleared.
//     RUN/STEP/NOP -> no effect (accepted).
//   - Simultaneous: a PAUSE accepted on the terminal-count cycle wins; no new step starts.
//   - Run period = DIV_FACTOR + 2 + SETTLE_CYCLES + HOLD_CYCLES cycles.
//   - Internal per-state counters are sized for the parameters; no wrap occurs within a state.
// CONFIGURATION
//   WORLD_STEP_LIMIT_EN defined:
//     - step_count increments at each S_UPDATE and saturates at MAX_STEPS.
//     - When S_UPDATE completes step MAX_STEPS: running=0, limit_hit=1, next state S_STOP.
//     - While limit_hit=1, RUN and STEP are accepted but ignored.
//     - RUN is honoured only after reset, which clears step_count and limit_hit.
//   WORLD_STEP_LIMIT_EN undefined:
//     - No step counter logic; step_count=0 and limit_hit=0 constantly.
//     - Runs indefinitely.
// TESTING (DIV_FACTOR=10, SETTLE_CYCLES=2, HOLD_CYCLES=4; acceptance at cycle 0)
//   1. STEP in S_STOP -> sense_en cycle 1; robot_clock=1 cycles 4-7; update_en cycle 8;
//      S_STOP and cmd_ready=1 at cycle 9; running stays 0.
//   2. RUN -> sense_en at cycles 1, 19, 37; update_en at 8, 26, 44; running=1.
//   3. RUN, then PAUSE presented at cycle 5 -> cmd_ready=0 cycles 1-8; PAUSE accepted
//      cycle 9; running=0 at 10; no sense_en at 19.
//   4. RUN, reset_key=0 at cycle 5 -> robot_clock falls without a clock edge; no update_en;
//      after release, outputs stay idle until a new command.
//   5. DIV_FACTOR=1, RUN -> back-to-back steps with period 9; sense_en at 1, 10, 19.
//   6. WORLD_STEP_LIMIT_EN, MAX_STEPS=3, RUN -> exactly 3 update_en pulses; step_count=3;
//      limit_hit=1; running=0; further RUN ignored until reset.

Source files
------------

// File: rtl/world_step_sequencer.sv
// world_step_sequencer: run/pause/single-step sequencer for sense -> settle -> clock -> update.
// Optional step limit enabled by defining WORLD_STEP_LIMIT_EN.
module world_step_sequencer #(
  parameter logic [27:0] DIV_FACTOR    = 28'd200000000,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          HOLD_CYCLES   = 4,
  parameter logic [15:0] MAX_STEPS     = 16'd1000
) (
  input  logic        clock_50,
  input  logic        reset_key,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_code,
  output logic        cmd_ready,
  output logic        sense_en,
  output logic        robot_clock,
  output logic        update_en,
  output logic        running,
  output logic        busy,
  output logic [15:0] step_count,
  output logic        limit_hit
);

  localparam int PMAX =
    (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int PW = $clog2(PMAX + 1);
  localparam logic [PW-1:0] SET_LAST  = PW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LAST = PW'(HOLD_CYCLES - 1);
  localparam logic [27:0]   DIV_LAST  = DIV_FACTOR - 28'd1;

  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_PAUSE = 2'b10;
  localparam logic [1:0] C_STEP  = 2'b11;

  localparam int I_STOP   = 0;
  localparam int I_WAIT   = 1;
  localparam int I_SENSE  = 2;
  localparam int I_SETTLE = 3;
  localparam int I_CLK    = 4;
  localparam int I_UPDATE = 5;

  // One-hot so every output is a single flop bit and robot_clock cannot glitch.
  typedef enum logic [5:0] {
    S_STOP   = 6'b000001,
    S_WAIT   = 6'b000010,
    S_SENSE  = 6'b000100,
    S_SETTLE = 6'b001000,
    S_CLK    = 6'b010000,
    S_UPDATE = 6'b100000
  } state_t;

  state_t        state, state_nx;
  logic [27:0]   div_q, div_nx;
  logic [PW-1:0] ph_q, ph_nx;
  logic          run_q, run_nx;
  logic [15:0]   cnt_q;
  logic          lim_q;
  logic          last_step;
  logic          accept;

  assign cmd_ready   = state[I_STOP] | state[I_WAIT];
  assign busy        = ~cmd_ready;
  assign sense_en    = state[I_SENSE];
  assign robot_clock = state[I_CLK];
  assign update_en   = state[I_UPDATE];
  assign running     = run_q;
  assign step_count  = cnt_q;
  assign limit_hit   = lim_q;
  assign accept      = cmd_valid & cmd_ready;

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state <= S_STOP;
      div_q <= '0;
      ph_q  <= '0;
      run_q <= 1'b0;
    end else begin
      state <= state_nx;
      div_q <= div_nx;
      ph_q  <= ph_nx;
      run_q <= run_nx;
    end
  end

  always_comb begin
    state_nx = state;
    div_nx   = div_q;
    ph_nx    = ph_q;
    run_nx   = run_q;
    unique case (1'b1)
      state[I_STOP]: begin
        if (accept && !lim_q) begin
          if (cmd_code == C_RUN) begin
            run_nx   = 1'b1;
            state_nx = S_SENSE;
          end else if (cmd_code == C_STEP) begin
            state_nx = S_SENSE;
          end
        end
      end
      state[I_WAIT]: begin
        // PAUSE beats the terminal count on the same cycle.
        if (accept && cmd_code == C_PAUSE) begin
          run_nx   = 1'b0;
          div_nx   = '0;
          state_nx = S_STOP;
        end else if (div_q == DIV_LAST) begin
          div_nx   = '0;
          state_nx = S_SENSE;
        end else begin
          div_nx = div_q + 28'd1;
        end
      end
      state[I_SENSE]: begin
        ph_nx    = '0;
        state_nx = S_SETTLE;
      end
      state[I_SETTLE]: begin
        if (ph_q == SET_LAST) begin
          ph_nx    = '0;
          state_nx = S_CLK;
        end else begin
          ph_nx = ph_q + 1'b1;
        end
      end
      state[I_CLK]: begin
        if (ph_q == HOLD_LAST) begin
          ph_nx    = '0;
          state_nx = S_UPDATE;
        end else begin
          ph_nx = ph_q + 1'b1;
        end
      end
      state[I_UPDATE]: begin
        if (last_step) begin
          run_nx   = 1'b0;
          state_nx = S_STOP;
        end else begin
          state_nx = run_q ? S_WAIT : S_STOP;
        end
      end
      default: state_nx = S_STOP;
    endcase
  end

`ifdef WORLD_STEP_LIMIT_EN
  assign last_step = (cnt_q + 16'd1 == MAX_STEPS);

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      cnt_q <= '0;
      lim_q <= 1'b0;
    end else if (state[I_UPDATE]) begin
      if (cnt_q != MAX_STEPS) cnt_q <= cnt_q + 16'd1;
      if (last_step) lim_q <= 1'b1;
    end
  end
`else
  logic unused_max;
  assign unused_max = ^MAX_STEPS;
  assign last_step  = 1'b0;
  assign cnt_q      = '0;
  assign lim_q      = 1'b0;
`endif

endmodule
